// File: rtl/axil_pkg.sv
// -----------------------------------------------------------------------------
// axil_pkg
// Definitions shared by the AXI4-Lite master bridge and its sub-modules:
//   - state_e               : bridge FSM state encoding
//   - RESP_*                : AXI4-Lite response codes
//   - DEFAULT_TIMEOUT_CYCLES: default per-transaction response timeout
//   - resp_is_err()         : maps a BRESP/RRESP code to the core's error flag
// -----------------------------------------------------------------------------
package axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_READ   = 3'd2,
        ST_RESP   = 3'd3,
        ST_ORPHAN = 3'd4
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1023;

    // EXOKAY is folded into OKAY; SLVERR and DECERR both report an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axil_master_bridge_if.sv
// -----------------------------------------------------------------------------
// axil_master_bridge_if
// AXI4-Lite bus bundle (AW, W, B, AR, R channels).
//   master modport: driven by the bridge (valids, addresses, data, bready/rready)
//   slave  modport: driven by a peripheral (readies, responses, read data)
// Clock and reset are not part of the bundle; they stay plain ports.
// -----------------------------------------------------------------------------
interface axil_master_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
);

    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;

    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;

    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, input  awready,
        output wdata,  wstrb,  wvalid,  input  wready,
        input  bresp,  bvalid,          output bready,
        output araddr, arprot, arvalid, input  arready,
        input  rdata,  rresp,  rvalid,  output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata,  wstrb,  wvalid,  output wready,
        output bresp,  bvalid,          input  bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata,  rresp,  rvalid,  input  rready
    );

endinterface

// File: rtl/axil_timeout.sv
// -----------------------------------------------------------------------------
// axil_timeout
// Response timeout counter for the bridge.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count (request accepted)
//   enable     : count this cycle (bridge waiting in WRITE/READ)
//   expired    : combinational pulse in the last waiting cycle; the bridge
//                registers the error so rsp_valid appears TIMEOUT_CYCLES
//                cycles after the request was accepted
// TIMEOUT_CYCLES = 0 removes the counter and never expires.
// -----------------------------------------------------------------------------
module axil_timeout
    import axil_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    if (TIMEOUT_CYCLES == 0) begin : g_off
        logic unused_ctrl;
        assign unused_ctrl = clear | enable | clk | rst_n;
        assign expired     = 1'b0;
    end else begin : g_on
        localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
        // Accept cycle -> first WRITE/READ cycle costs one cycle, and the
        // registered rsp_valid costs one more, so the error is decided when
        // the count (cycles spent waiting before this one) hits TIMEOUT-2.
        localparam int unsigned EXPIRE_AT = (TIMEOUT_CYCLES >= 2) ? TIMEOUT_CYCLES - 2 : 0;

        logic [CNT_W-1:0] count;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                count <= '0;
            end else if (clear) begin
                count <= '0;
            end else if (enable && !expired) begin
                count <= count + CNT_W'(1);
            end
        end

        assign expired = enable && (count >= CNT_W'(EXPIRE_AT));
    end

endmodule

// File: rtl/axil_master_bridge.sv
// -----------------------------------------------------------------------------
// axil_master_bridge
// Single-outstanding bridge from the core's load/store request/response port
// to an AXI4-Lite master. A hung slave is cut off by a response timeout that
// returns an error to the core; the late bus response is still drained.
//   m_axi_aclk, m_axi_aresetn : clock, asynchronous active-low reset
//   req_valid/req_ready       : request handshake (req_we, req_addr,
//                               req_wdata, req_wstrb)
//   rsp_valid/rsp_ready       : response handshake (rsp_rdata, rsp_err)
//   m_axi                     : AXI4-Lite master bundle
// Only AXI_DATA_WIDTH = 32 is supported.
// -----------------------------------------------------------------------------
module axil_master_bridge
    import axil_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 16,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                        m_axi_aclk,
    input  logic                        m_axi_aresetn,

    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   req_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] req_wstrb,

    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic                        rsp_err,

    axil_master_bridge_if.master        m_axi
);

    state_e                      state;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb_q;

    logic req_fire, rsp_fire;
    logic aw_fire, w_fire, ar_fire, b_fire, r_fire;
    logic timer_en, expired;
    logic bus_pending, rsp_pending;

    assign req_fire = req_valid && req_ready;
    assign rsp_fire = rsp_valid && rsp_ready;
    assign aw_fire  = m_axi.awvalid && m_axi.awready;
    assign w_fire   = m_axi.wvalid  && m_axi.wready;
    assign ar_fire  = m_axi.arvalid && m_axi.arready;
    assign b_fire   = m_axi.bvalid  && m_axi.bready;
    assign r_fire   = m_axi.rvalid  && m_axi.rready;

    // ORPHAN bookkeeping: a response still owed after this cycle.
    assign bus_pending = (m_axi.bready && !m_axi.bvalid) || (m_axi.rready && !m_axi.rvalid);
    assign rsp_pending = rsp_valid && !rsp_ready;

    assign timer_en = (state == ST_WRITE) || (state == ST_READ);

    assign m_axi.awaddr = addr_q;
    assign m_axi.araddr = addr_q;
    assign m_axi.wdata  = wdata_q;
    assign m_axi.wstrb  = wstrb_q;
    assign m_axi.awprot = 3'b000;
    assign m_axi.arprot = 3'b000;

    axil_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (m_axi_aclk),
        .rst_n   (m_axi_aresetn),
        .clear   (req_fire),
        .enable  (timer_en),
        .expired (expired)
    );

    // NOTE: every register here is assigned with <= so all branches read the
    // pre-edge values and later assignments in the block cleanly override
    // earlier ones (e.g. a valid set on accept wins over its handshake clear).
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state         <= ST_IDLE;
            req_ready     <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            m_axi.awvalid <= 1'b0;
            m_axi.wvalid  <= 1'b0;
            m_axi.arvalid <= 1'b0;
            m_axi.bready  <= 1'b0;
            m_axi.rready  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
        end else begin
            // A channel valid is only ever retired by its own handshake, in
            // any state, so a timeout never withdraws a pending request.
            if (aw_fire) m_axi.awvalid <= 1'b0;
            if (w_fire)  m_axi.wvalid  <= 1'b0;
            if (ar_fire) m_axi.arvalid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_fire) begin
                        req_ready <= 1'b0;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        wstrb_q   <= req_wstrb;
                        if (req_we) begin
                            m_axi.awvalid <= 1'b1;
                            m_axi.wvalid  <= 1'b1;
                            m_axi.bready  <= 1'b1;
                            state         <= ST_WRITE;
                        end else begin
                            m_axi.arvalid <= 1'b1;
                            m_axi.rready  <= 1'b1;
                            state         <= ST_READ;
                        end
                    end
                end

                // A real response in the expiry cycle wins over the timeout.
                ST_WRITE: begin
                    if (b_fire) begin
                        m_axi.bready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_err      <= resp_is_err(m_axi.bresp);
                        rsp_rdata    <= '0;
                        state        <= ST_RESP;
                    end else if (expired) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= ST_ORPHAN;
                    end
                end

                ST_READ: begin
                    if (r_fire) begin
                        m_axi.rready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_err      <= resp_is_err(m_axi.rresp);
                        rsp_rdata    <= m_axi.rdata;
                        state        <= ST_RESP;
                    end else if (expired) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= ST_ORPHAN;
                    end
                end

                ST_RESP: begin
                    if (rsp_fire) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                // Error already reported; drain the late B/R and wait for the
                // core to take the error, whichever finishes last.
                ST_ORPHAN: begin
                    if (b_fire)   m_axi.bready <= 1'b0;
                    if (r_fire)   m_axi.rready <= 1'b0;
                    if (rsp_fire) rsp_valid    <= 1'b0;
                    if (!bus_pending && !rsp_pending) begin
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
